alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and results.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream instruction/operands valid.
REQ-005 in_ready  output  1  queue can accept a beat this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 rs1_data, rs2_data  input  WIDTH each  register-file operands.
REQ-008 flush  input  1  discard all queued entries.
REQ-009 out_valid  output  1  head entry valid toward ALU.
REQ-010 out_ready  input  1  ALU stage consumes head this cycle.
REQ-011 a, b  output  WIDTH each  ALU operands of head entry.
REQ-012 alu_ctrl  output  3  ALU operation code of head entry.
REQ-013 aluflag  output  1  ALU operation qualifier of head entry.
REQ-014 is_branch  output  1  head entry is BEQ/BNE (zero flag consumer).
REQ-015 illegal  output  1  head entry is an unsupported encoding.

Function
REQ-016 Block SHALL decode instructions into ALU controls and hold them in a 2-entry FIFO; decode happens on enqueue, outputs are head-entry registers, no combinational in->out path.
REQ-017 Occupancy states: EMPTY(0), ONE(1), FULL(2); in_ready = state != FULL, out_valid = state != EMPTY, both purely from registered state.
REQ-018 Enqueue when in_valid && in_ready; dequeue when out_valid && out_ready; simultaneous enqueue+dequeue in ONE keeps ONE, new entry becomes head next cycle; in FULL only dequeue possible (FULL->ONE).
REQ-019 Transitions: EMPTY-enq->ONE; ONE-enq->FULL; ONE-deq->EMPTY; FULL-deq->ONE; no event holds state.
REQ-020 Entry order strictly FIFO; head outputs SHALL remain stable while out_valid && !out_ready.
REQ-021 Opcode 0110011 (R): funct3 000 -> ctrl 000 (ADD) if funct7=0000000, ctrl 001 (SUB) if 0100000; 001 -> ctrl 110 flag 1 (SLL); 010 -> ctrl 100 flag 1 (SLT); 100 -> ctrl 110 flag 0 (XOR); 101 -> ctrl 011, flag 0 (SRL, funct7=0000000) / flag 1 (SRA, funct7=0100000); 110 -> ctrl 111 (OR); 111 -> ctrl 100 flag 0 (AND); b = rs2_data.
REQ-022 Opcode 0010011 (I): same mapping on funct3 without SUB; b = sign-extended instr[31:20]; SLLI/SRLI/SRAI use instr[31:25] as funct7 as in REQ-021.
REQ-023 Shift ops (R and I) SHALL zero-extend b[4:0] only into b (bits WIDTH-1:5 cleared); a = rs1_data for all legal ops.
REQ-024 Opcode 1100011: funct3 000/001 -> ctrl 001 flag 0, a = rs1_data, b = rs2_data, is_branch = 1; other funct3 illegal.
REQ-025 Unsupported: funct3 011 (SLTU/SLTIU), bad funct7 values, any other opcode -> illegal = 1, ctrl 000, flag 0, a = b = 0, is_branch = 0; entry still enqueued and dequeued normally.
REQ-026 aluflag SHALL be 0 for every encoding not listed with flag 1.
REQ-027 flush SHALL force state EMPTY next edge, overriding simultaneous enqueue and dequeue; in_ready high in the following cycle.
REQ-028 Non-head entry payloads are don't-care; only head fields are observable.

Reset
REQ-029 On reset assertion, immediately (asynchronously): state EMPTY, out_valid 0, in_ready 1, a = b = 0, alu_ctrl 000, aluflag 0, is_branch 0, illegal 0.
REQ-030 Reset mid-operation SHALL discard all entries; first enqueue after deassertion occurs no earlier than the first rising edge with reset low.

Verification
REQ-031 Reset, then enqueue ADD x(rs1=5, rs2=7) -> next cycle out_valid 1, a=5, b=7, ctrl 000, flag 0.
REQ-032 Enqueue SRAI shamt 3 with rs1=0x80000000, out_ready 0 -> a=0x80000000, b=3, ctrl 011, flag 1 held stable across 3 stalled cycles.
REQ-033 Three back-to-back enqueues (SUB, SLTI imm=-1, XOR) with out_ready 0 -> in_ready drops after 2nd; release out_ready -> SUB then SLTI (b=0xFFFFFFFF, ctrl 100 flag 1) in order; third accepted only when in_ready returns.
REQ-034 State FULL, assert flush together with in_valid and out_ready -> next cycle out_valid 0, in_ready 1, nothing accepted.
REQ-035 Enqueue SLTU (0110011, funct3 011) and opcode 0000000 -> illegal 1, ctrl 000, a=b=0; BNE -> ctrl 001, is_branch 1.
REQ-036 Assert reset asynchronously between edges while FULL -> out_valid 0 and outputs zero before the next clock edge.

Source files
------------

// File: rtl/alu_issue_queue.sv
`timescale 1ns/1ps
// alu_issue_queue: decodes RV32I ALU/branch instructions on enqueue and holds
// the decoded controls plus operands in a 2-entry FIFO feeding the ALU stage.
// The head entry drives the outputs straight from registers.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake (instr, rs1_data, rs2_data)
//   flush                 drop every queued entry
//   out_valid / out_ready ALU-side handshake for the head entry
//   a, b                  head operands
//   alu_ctrl, aluflag     head ALU operation and qualifier
//   is_branch, illegal    head is BEQ/BNE, head is an unsupported encoding
module alu_issue_queue #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       alu_ctrl,
  output logic             aluflag,
  output logic             is_branch,
  output logic             illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [2:0] CTRL_ADD   = 3'b000;
  localparam logic [2:0] CTRL_SUB   = 3'b001;
  localparam logic [2:0] CTRL_SHR   = 3'b011;
  localparam logic [2:0] CTRL_SLT   = 3'b100;
  localparam logic [2:0] CTRL_SLLX  = 3'b110;
  localparam logic [2:0] CTRL_OR    = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic             flag;
    logic             br;
    logic             ill;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  entry_t head, tail, dec;
  logic   enq, deq;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [WIDTH-1:0] imm_sext;
  logic             unused_rd;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_sext  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign unused_rd = ^instr[11:7];

  // Instruction decode into a queue entry; unsupported encodings become a zeroed illegal entry.
  always_comb begin
    logic             ok;
    logic             is_imm;
    logic             shift;
    logic [2:0]       ctrl;
    logic             flag;
    logic             br;
    logic [WIDTH-1:0] operand;

    dec     = '0;
    ok      = 1'b0;
    is_imm  = (opcode == OP_I);
    shift   = 1'b0;
    ctrl    = CTRL_ADD;
    flag    = 1'b0;
    br      = 1'b0;
    operand = rs2_data;

    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          3'b000: begin
            if (is_imm || funct7 == F7_STD) begin
              ok = 1'b1; ctrl = CTRL_ADD;
            end else if (funct7 == F7_ALT) begin
              ok = 1'b1; ctrl = CTRL_SUB;
            end
          end
          3'b001: if (funct7 == F7_STD) begin
            ok = 1'b1; ctrl = CTRL_SLLX; flag = 1'b1; shift = 1'b1;
          end
          3'b010: if (is_imm || funct7 == F7_STD) begin
            ok = 1'b1; ctrl = CTRL_SLT; flag = 1'b1;
          end
          3'b100: if (is_imm || funct7 == F7_STD) begin
            ok = 1'b1; ctrl = CTRL_SLLX;
          end
          3'b101: begin
            if (funct7 == F7_STD) begin
              ok = 1'b1; ctrl = CTRL_SHR; shift = 1'b1;
            end else if (funct7 == F7_ALT) begin
              ok = 1'b1; ctrl = CTRL_SHR; flag = 1'b1; shift = 1'b1;
            end
          end
          3'b110: if (is_imm || funct7 == F7_STD) begin
            ok = 1'b1; ctrl = CTRL_OR;
          end
          3'b111: if (is_imm || funct7 == F7_STD) begin
            ok = 1'b1; ctrl = CTRL_SLT;
          end
          default: ok = 1'b0;
        endcase
        if (is_imm) operand = imm_sext;
        // Shift amount only: upper bits of b are cleared.
        if (shift) operand = WIDTH'(operand[4:0]);
      end
      OP_B: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          ok = 1'b1; ctrl = CTRL_SUB; br = 1'b1;
        end
      end
      default: ok = 1'b0;
    endcase

    if (ok) begin
      dec.a    = rs1_data;
      dec.b    = operand;
      dec.ctrl = ctrl;
      dec.flag = flag;
      dec.br   = br;
    end else begin
      dec.ill  = 1'b1;
    end
  end

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  // Occupancy next state; flush wins over any handshake.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (enq) state_nxt = ONE;
        ONE: begin
          if (enq && !deq)      state_nxt = FULL;
          else if (deq && !enq) state_nxt = EMPTY;
        end
        FULL:    if (deq) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State, handshake flags and entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      if (!flush) begin
        case (state)
          EMPTY: if (enq) head <= dec;
          ONE: begin
            // Enqueue with dequeue replaces the head directly.
            if (enq && deq) head <= dec;
            else if (enq)   tail <= dec;
          end
          FULL:    if (deq) head <= tail;
          default: head <= head;
        endcase
      end
    end
  end

  assign a         = head.a;
  assign b         = head.b;
  assign alu_ctrl  = head.ctrl;
  assign aluflag   = head.flag;
  assign is_branch = head.br;
  assign illegal   = head.ill;

endmodule

// File: tb/tb_alu_issue_queue.sv
`timescale 1ns/1ps
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a, b;
  logic [2:0]  alu_ctrl;
  logic        aluflag, is_branch, illegal;

  int errors = 0;
  int checks = 0;

  alu_issue_queue #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .aluflag(aluflag),
    .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic        flag;
    logic        br;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  function automatic logic [31:0] mk_b(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
  endfunction

  task automatic add_vec(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] ec,
                         input logic ef, input logic ebr, input logic eil);
    vec_t v;
    v.instr = i; v.rs1 = r1; v.rs2 = r2;
    v.a = ea; v.b = eb; v.ctrl = ec; v.flag = ef; v.br = ebr; v.ill = eil;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [2:0] ec, input logic ef, input logic ebr, input logic eil);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_a"},         a, ea);
    check({tag, "_b"},         b, eb);
    check({tag, "_ctrl"},      32'(alu_ctrl), 32'(ec));
    check({tag, "_flag"},      32'(aluflag), 32'(ef));
    check({tag, "_branch"},    32'(is_branch), 32'(ebr));
    check({tag, "_illegal"},   32'(illegal), 32'(eil));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    instr = i; rs1_data = r1; rs2_data = r2;
  endtask

  initial begin
    // Decode table: one entry through an empty queue each.
    add_vec(mk_r(7'h00, 3'b000), 32'd5, 32'd7, 32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 1'b0);
    add_vec(mk_r(7'h20, 3'b000), 32'd5, 32'd7, 32'd5, 32'd7, 3'b001, 1'b0, 1'b0, 1'b0);
    add_vec(mk_r(7'h00, 3'b001), 32'd5, 32'h23, 32'd5, 32'd3, 3'b110, 1'b1, 1'b0, 1'b0);
    add_vec(mk_r(7'h00, 3'b010), 32'd5, 32'd7, 32'd5, 32'd7, 3'b100, 1'b1, 1'b0, 1'b0);
    add_vec(mk_r(7'h00, 3'b100), 32'd5, 32'd7, 32'd5, 32'd7, 3'b110, 1'b0, 1'b0, 1'b0);
    add_vec(mk_r(7'h00, 3'b101), 32'd5, 32'hFFFFFFE4, 32'd5, 32'd4, 3'b011, 1'b0, 1'b0, 1'b0);
    add_vec(mk_r(7'h20, 3'b101), 32'h80000000, 32'h25, 32'h80000000, 32'd5, 3'b011, 1'b1, 1'b0, 1'b0);
    add_vec(mk_r(7'h00, 3'b110), 32'd5, 32'd7, 32'd5, 32'd7, 3'b111, 1'b0, 1'b0, 1'b0);
    add_vec(mk_r(7'h00, 3'b111), 32'd5, 32'd7, 32'd5, 32'd7, 3'b100, 1'b0, 1'b0, 1'b0);
    add_vec(mk_r(7'h01, 3'b000), 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_vec(mk_r(7'h00, 3'b011), 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_vec(mk_r(7'h20, 3'b100), 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_vec(mk_i(12'h800, 3'b000), 32'd5, 32'd7, 32'd5, 32'hFFFFF800, 3'b000, 1'b0, 1'b0, 1'b0);
    add_vec(mk_i(12'h0F0, 3'b110), 32'd5, 32'd7, 32'd5, 32'h000000F0, 3'b111, 1'b0, 1'b0, 1'b0);
    add_vec(mk_i(12'h01F, 3'b001), 32'd5, 32'd7, 32'd5, 32'd31, 3'b110, 1'b1, 1'b0, 1'b0);
    add_vec(mk_i(12'h403, 3'b101), 32'd5, 32'd7, 32'd5, 32'd3, 3'b011, 1'b1, 1'b0, 1'b0);
    add_vec(mk_i(12'h005, 3'b101), 32'd5, 32'd7, 32'd5, 32'd5, 3'b011, 1'b0, 1'b0, 1'b0);
    add_vec(mk_i(12'h41F, 3'b001), 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_vec(mk_i(12'h001, 3'b011), 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_vec(mk_i(12'hFFF, 3'b111), 32'd5, 32'd7, 32'd5, 32'hFFFFFFFF, 3'b100, 1'b0, 1'b0, 1'b0);
    add_vec(mk_i(12'h7FF, 3'b100), 32'd5, 32'd7, 32'd5, 32'h000007FF, 3'b110, 1'b0, 1'b0, 1'b0);
    add_vec(mk_i(12'hFFF, 3'b010), 32'd5, 32'd7, 32'd5, 32'hFFFFFFFF, 3'b100, 1'b1, 1'b0, 1'b0);
    add_vec(mk_b(3'b000), 32'd5, 32'd7, 32'd5, 32'd7, 3'b001, 1'b0, 1'b1, 1'b0);
    add_vec(mk_b(3'b001), 32'd9, 32'd11, 32'd9, 32'd11, 3'b001, 1'b0, 1'b1, 1'b0);
    add_vec(mk_b(3'b100), 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_vec(32'h00000000, 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_vec(32'h000012B7, 32'd5, 32'd7, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    check_idle("reset");
    check_head_zero();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_idle("post_reset");

    // Table-driven decode: enqueue, scramble inputs, check head, dequeue.
    foreach (vq[i]) begin
      drive(vq[i].instr, vq[i].rs1, vq[i].rs2);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      drive(32'hFFFFFFFF, 32'hDEADBEEF, 32'hCAFEF00D);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      check_head($sformatf("vec%0d", i), vq[i].a, vq[i].b, vq[i].ctrl, vq[i].flag, vq[i].br, vq[i].ill);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // SRAI head held stable across stalled cycles.
    drive(mk_i(12'h403, 3'b101), 32'h80000000, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(32'($urandom), 32'($urandom), 32'($urandom));
      check_head($sformatf("stall%0d", c), 32'h80000000, 32'd3, 3'b011, 1'b1, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_drained", 32'(out_valid), 32'd0);

    // Back-to-back SUB, SLTI -1, XOR with a blocked consumer.
    drive(mk_r(7'h20, 3'b000), 32'd10, 32'd3);
    in_valid = 1'b1;
    tick();
    check("b2b_ready_after1", 32'(in_ready), 32'd1);
    drive(mk_i(12'hFFF, 3'b010), 32'd9, 32'd0);
    tick();
    check("b2b_ready_after2", 32'(in_ready), 32'd0);
    drive(mk_r(7'h00, 3'b100), 32'd21, 32'd22);
    tick();
    check("b2b_full_hold", 32'(in_ready), 32'd0);
    check_head("b2b_sub", 32'd10, 32'd3, 3'b001, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check_head("b2b_slti", 32'd9, 32'hFFFFFFFF, 3'b100, 1'b1, 1'b0, 1'b0);
    check("b2b_ready_back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_head("b2b_xor", 32'd21, 32'd22, 3'b110, 1'b0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Flush while FULL with enqueue and dequeue requested.
    drive(mk_r(7'h00, 3'b000), 32'd1, 32'd2);
    in_valid = 1'b1;
    tick();
    tick();
    check("flush_full_setup", 32'(in_ready), 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_idle("flush_full");
    tick();
    check_idle("flush_full_after");

    // Flush in ONE overrides a simultaneous enqueue.
    in_valid = 1'b1;
    tick();
    check("flush_one_setup", 32'(out_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_idle("flush_one");
    tick();
    check_idle("flush_one_after");

    // Asynchronous reset mid-cycle while FULL.
    drive(mk_r(7'h20, 3'b101), 32'd5, 32'd6);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("areset_setup", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check_idle("areset");
    check_head_zero();
    #1 reset = 1'b0;
    tick();
    check_idle("areset_discard");
    drive(mk_r(7'h00, 3'b000), 32'd5, 32'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_head("areset_add", 32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic check_head_zero();
    check("zero_a",       a, 32'd0);
    check("zero_b",       b, 32'd0);
    check("zero_ctrl",    32'(alu_ctrl), 32'd0);
    check("zero_flag",    32'(aluflag), 32'd0);
    check("zero_branch",  32'(is_branch), 32'd0);
    check("zero_illegal", 32'(illegal), 32'd0);
  endtask

endmodule
